// File: rtl/uart_tx_unit.sv
// uart_tx_unit: 8N1 transmit-only UART with built-in baud divider.
// Frame = start bit, 8 data bits LSB first, stop bit; DIV clocks per bit.
module uart_tx_unit #(
  parameter int INPUT_CLOCK  = 25000000,
  parameter int OUTPUT_CLOCK = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       baud_tick
);

  localparam int DIV = INPUT_CLOCK / OUTPUT_CLOCK;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_unit: INPUT_CLOCK/OUTPUT_CLOCK must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          tick;
  logic [CW-1:0] cnt_nx;

  assign tick   = (state_q != IDLE) && (cnt_q == LAST);
  assign cnt_nx = tick ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          sh_d    = data;
          state_d = START;
        end
      end
      START: begin
        cnt_d = cnt_nx;
        if (tick) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        cnt_d = cnt_nx;
        if (tick) begin
          sh_d  = {1'b0, sh_q[7:1]};
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        cnt_d = cnt_nx;
        if (tick) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from next state so tx/busy stay registered.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b0;
    unique case (state_d)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
      START: begin
        tx_d   = 1'b0;
        busy_d = 1'b1;
      end
      DATA: begin
        tx_d   = sh_d[0];
        busy_d = 1'b1;
      end
      STOP: begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
      end
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign baud_tick = tick;

endmodule

// File: tb/tb_uart_tx_unit.sv
// tb_uart_tx_unit: scoreboard bench for uart_tx_unit.
// Stimulus queues expected frames; a monitor decodes tx and compares.
module tb_uart_tx_unit;

  localparam int DIV   = 25;
  localparam int FRAME = 10 * DIV;

  typedef struct {
    logic [7:0] d;
    int         low;
    int         gap;
    bit         abort;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] data;
  logic       tx;
  logic       busy;
  logic       baud_tick;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  uart_tx_unit #(
    .INPUT_CLOCK (25000000),
    .OUTPUT_CLOCK(1000000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .data     (data),
    .tx       (tx),
    .busy     (busy),
    .baud_tick(baud_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Monitor: decodes each busy window and scores it against the queue.
  bit         prev_busy = 1'b0;
  bit         in_frame  = 1'b0;
  int         pos, low, ticks, idle;
  logic [9:0] bits;

  always @(negedge clk) begin
    if (!rst_n) begin
      if (in_frame) begin
        if (sb.size() == 0) begin
          chk("abort_unexpected", 1, 0);
        end else begin
          chk("abort_expected", int'(sb[0].abort), 1);
          void'(sb.pop_front());
        end
      end
      in_frame  = 1'b0;
      prev_busy = 1'b0;
      idle      = 0;
    end else begin
      if (busy && !prev_busy) begin
        in_frame = 1'b1;
        pos      = 0;
        low      = 0;
        ticks    = 0;
        bits     = '0;
        if (sb.size() == 0) begin
          chk("unexpected_frame", 1, 0);
        end else if (sb[0].gap >= 0) begin
          chk("idle_gap", idle, sb[0].gap);
        end
      end
      if (busy && in_frame) begin
        if (tx == 1'b0) low++;
        if (baud_tick) ticks++;
        if (pos % DIV == DIV / 2 && pos / DIV < 10) begin
          bits[pos/DIV] = tx;
        end
        pos++;
      end
      if (!busy && prev_busy && in_frame) begin
        in_frame = 1'b0;
        chk("frame_len", pos, FRAME);
        chk("start_bit", int'(bits[0]), 0);
        chk("stop_bit", int'(bits[9]), 1);
        chk("baud_ticks", ticks, 10);
        if (sb.size() != 0) begin
          chk("data_byte", int'(bits[8:1]), int'(sb[0].d));
          chk("tx_low_cycles", low, sb[0].low);
          chk("abort_flag", int'(sb[0].abort), 0);
          void'(sb.pop_front());
        end
      end
      if (busy) idle = 0;
      else idle++;
      prev_busy = busy;
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(logic [7:0] d, int low, int gap, bit ab);
    exp_t e;
    e.d     = d;
    e.low   = low;
    e.gap   = gap;
    e.abort = ab;
    sb.push_back(e);
  endtask

  task automatic pulse(logic [7:0] d, int n);
    data  = d;
    start = 1'b1;
    cyc(n);
    start = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    cyc(1);
    while (busy && n < budget) begin
      cyc(1);
      n++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    data  = 8'h55;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_tx", int'(tx), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_tick", int'(baud_tick), 0);
    end
    cyc(1);
    start = 1'b0;
    rst_n = 1'b1;
    cyc(5);
    chk("post_rst_tx", int'(tx), 1);
    chk("post_rst_busy", int'(busy), 0);

    // 0xC0: start + bits 0..5 low = 7 bit times
    push(8'hC0, 175, -1, 1'b0);
    pulse(8'hC0, 3);
    wait_idle(400);
    cyc(50);

    push(8'hA5, 125, -1, 1'b0);
    pulse(8'hA5, 1);
    wait_idle(400);
    cyc(10);

    // start + new data mid-frame must be ignored
    push(8'h00, 225, -1, 1'b0);
    pulse(8'h00, 1);
    cyc(100);
    pulse(8'hFF, 2);
    wait_idle(400);
    cyc(300);
    chk("no_retrigger", sb.size(), 0);

    // start held high: back-to-back frames, one idle cycle apart
    push(8'h3C, 125, -1, 1'b0);
    push(8'h3C, 125, 1, 1'b0);
    push(8'h3C, 125, 1, 1'b0);
    data  = 8'h3C;
    start = 1'b1;
    cyc(2 * (FRAME + 1) + 10);
    start = 1'b0;
    wait_idle(400);
    cyc(20);

    // reset mid-frame aborts immediately
    push(8'hA5, 0, -1, 1'b1);
    pulse(8'hA5, 1);
    cyc(99);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_tx", int'(tx), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_tick", int'(baud_tick), 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(5);
    chk("abort_idle_busy", int'(busy), 0);

    push(8'h5A, 125, -1, 1'b0);
    pulse(8'h5A, 1);
    wait_idle(400);
    cyc(10);

    chk("queue_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_unit.md
# uart_tx_unit

Transmit-only 8N1 UART serializer with an integrated baud-rate divider, operating from a single system clock. It accepts a byte on a start request, shifts it out LSB-first on a single serial line (start bit, 8 data bits, stop bit), and signals activity on `busy`. It sits between a byte producer and the board's serial TX pin.

## Interface

Parameters:
- `INPUT_CLOCK`, 25000000: system clock frequency in Hz.
- `OUTPUT_CLOCK`, 1000000: baud rate in bit/s.
- Derived: `DIV = INPUT_CLOCK / OUTPUT_CLOCK`, using integer division. `DIV` must be ≥ 2; elaboration fails otherwise.

Ports:
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: transmit request, level-sampled while idle.
- `data`, input, 8: byte to send. Sampled only in the accept cycle.
- `tx`, output, 1: serial line, idle high.
- `busy`, output, 1: high from the cycle after accept until the stop bit completes.
- `baud_tick`, output, 1: one-cycle pulse marking each bit-period boundary. Provided for debug and verification.

## Operation

- Reset (`rst_n` = 0, asynchronous, effective immediately):
  - `tx` = 1, `busy` = 0, `baud_tick` = 0.
  - State = IDLE; divider counter = 0; bit counter = 0; shift register = 0.
- Baud divider:
  - Counter runs 0..DIV-1.
  - `baud_tick` = 1 in the cycle the counter equals DIV-1; the counter then wraps to 0.
  - In IDLE the counter is held at 0 and `baud_tick` = 0.
  - On accept, the counter restarts from 0, so every bit lasts exactly DIV cycles.
- State machine: IDLE → START → DATA → STOP → IDLE.
  - IDLE: `tx` = 1, `busy` = 0.
    - If `start` = 1 on a rising edge: latch `data` into the shift register, clear the divider, go to START.
  - START: `tx` = 0, `busy` = 1.
    - On `baud_tick`: go to DATA with bit index 0.
  - DATA: `tx` = shift register bit 0, i.e. `data[index]`, sent LSB first.
    - On `baud_tick`: shift right and increment the index.
    - After index 7 completes: go to STOP.
  - STOP: `tx` = 1.
    - On `baud_tick`: go to IDLE, `busy` = 0.
- `start` while `busy` = 1 is ignored. No queuing and no error flag.
- `start` held high across the end of a frame: a new frame is accepted in the first IDLE cycle. This gives back-to-back frames with exactly one idle cycle between the stop bit and the next start bit.
- `data` changes after accept do not affect the frame in progress.
- `tx` and `busy` are registered outputs with no combinational path from inputs.
- Reset asserted mid-frame aborts the frame: `tx` returns high and `busy` low immediately, with no partial stop bit.

## Timing

- Accept edge E (IDLE with `start` = 1): from E onward, `busy` = 1 and `tx` = 0.
- Start bit: `tx` = 0 for DIV cycles.
- Data bit k: occupies cycles DIV·(k+1) through DIV·(k+2)−1 after E.
- Stop bit: `tx` = 1 for DIV cycles.
- `busy` falls 10·DIV cycles after E. At default parameters: DIV = 25, bit time 1 µs, frame 250 cycles = 10 µs.
- Minimum spacing between accepts with `start` held high: 10·DIV + 1 cycles.
- `baud_tick` pulses exactly 10 times per frame, the last coinciding with the end of the stop bit.

## Test plan

- Reset: hold `rst_n` = 0 for 3 cycles with `start` = 1 → `tx` = 1 and `busy` = 0 throughout; no frame starts until `rst_n` = 1.
- Single byte 0xC0, `start` pulsed for 3 cycles, defaults → after 250 cycles `busy` falls.
  - `tx` = 0 for 175 cycles (start bit plus data bits 0–5).
  - `tx` = 1 for 75 cycles (bits 6 and 7 plus stop bit).
  - Only one frame is sent.
- Byte 0xA5 → bits 1,0,1,0,0,1,0,1 on `tx`, each 25 cycles; each bit checked at its mid-point.
- `start` and new `data` (0xFF) pulsed mid-frame while sending 0x00 → the 0x00 frame completes unchanged; no second frame follows.
- `start` held high continuously → consecutive frames, with `busy` low for exactly 1 cycle between them and each frame 250 cycles long.
- Reset asserted at cycle 100 of a frame → `tx` = 1 and `busy` = 0 immediately; after release, a new `start` produces a clean full frame.
